// File: rtl/slice_rr_arbiter.sv
// Round-robin arbiter that time-slices one shared resource among NREQ clients.
// Ownership rotates when the owner drops its request or its slice runs out.
module slice_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int SLICE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [SLICE_W-1:0] slice_len,
   output logic [NREQ-1:0]    grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic [SLICE_W-1:0] slice_cnt,
   output logic               expire
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [SLICE_W-1:0] cnt_q, cnt_d;
   logic [SLICE_W-1:0] len_q, len_d;
   logic               expire_q, expire_d;

   logic [ID_W-1:0]    idx;
   logic [ID_W-1:0]    win;
   logic               found;
   logic               take;

   // Search starts one past the last winner and wraps back onto it.
   always_comb begin
      idx   = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = last_q + ID_W'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      id_d     = id_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      expire_d = 1'b0;
      take     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) take = 1'b1;
         end
         BUSY: begin
            if (!req[id_q]) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
                  cnt_d   = '0;
               end
            // len 0 wraps to all-ones, giving a full 2^SLICE_W slice
            end else if (cnt_q == len_q - SLICE_W'(1)) begin
               expire_d = 1'b1;
               take     = 1'b1;
            end else begin
               cnt_d = cnt_q + SLICE_W'(1);
            end
         end
      endcase
      if (take) begin
         state_d = BUSY;
         grant_d = NREQ'(1) << win;
         id_d    = win;
         last_d  = win;
         cnt_d   = '0;
         len_d   = slice_len;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         id_q     <= '0;
         last_q   <= ID_W'(NREQ - 1);
         cnt_q    <= '0;
         len_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         id_q     <= id_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         expire_q <= expire_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = id_q;
   assign slice_cnt   = cnt_q;
   assign expire      = expire_q;

endmodule

// File: tb/tb_slice_rr_arbiter.sv
// Scoreboard bench for slice_rr_arbiter: a behavioural model queues the
// expected outputs per cycle and a monitor compares them after each edge.
module tb_slice_rr_arbiter;

   localparam int NREQ = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] slice_len;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic [3:0] slice_cnt;
   logic       expire;

   slice_rr_arbiter #(.NREQ(4), .ID_W(2), .SLICE_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .slice_len   (slice_len),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .slice_cnt   (slice_cnt),
      .expire      (expire)
   );

   always #5 clk = ~clk;

   logic [11:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;

   // model state: owner -1 means idle; elapsed counts cycles within the slice
   int m_owner   = -1;
   int m_last    = NREQ - 1;
   int m_elapsed = 0;
   int m_len     = 16;
   bit m_exp     = 0;

   function automatic int pick(input logic [3:0] rq, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (last + k) % NREQ;
         if (rq[i]) return i;
      end
      return -1;
   endfunction

   task automatic give(input int w, input logic [3:0] sl);
      m_owner   = w;
      m_last    = w;
      m_elapsed = 0;
      m_len     = (sl == 0) ? 16 : int'(sl);
   endtask

   task automatic model(input logic r, input logic [3:0] rq,
                        input logic [3:0] sl);
      int w;
      w     = pick(rq, m_last);
      m_exp = 0;
      if (r) begin
         m_owner   = -1;
         m_last    = NREQ - 1;
         m_elapsed = 0;
      end else if (m_owner < 0) begin
         if (w >= 0) give(w, sl);
      end else if (!rq[m_owner]) begin
         if (w >= 0) give(w, sl);
         else begin
            m_owner   = -1;
            m_elapsed = 0;
         end
      end else if (m_elapsed + 1 == m_len) begin
         m_exp = 1;
         give(w, sl);
      end else begin
         m_elapsed++;
      end
   endtask

   function automatic logic [11:0] expected();
      logic [3:0] g;
      logic [1:0] id;
      g  = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
      id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      return {g, (m_owner >= 0), id, 4'(m_elapsed), m_exp};
   endfunction

   task automatic step(input logic r, input logic [3:0] rq,
                       input logic [3:0] sl);
      @(negedge clk);
      reset     = r;
      req       = rq;
      slice_len = sl;
      model(r, rq, sl);
      exp_q.push_back(expected());
   endtask

   // monitor: every cycle the DUT presents a fresh output set
   initial begin
      logic [11:0] got, want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {grant, grant_valid, grant_id, slice_cnt, expire};
            n_chk++;
            if (got === want) n_pass++;
            else $display("FAIL cycle t=%0t got g=%b v=%b id=%0d cnt=%0d exp=%b want g=%b v=%b id=%0d cnt=%0d exp=%b",
                          $time, got[11:8], got[7], got[6:5], got[4:1], got[0],
                          want[11:8], want[7], want[6:5], want[4:1], want[0]);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      req       = '0;
      slice_len = '0;
      // idle after reset
      step(1, 4'b0000, 4'd3);
      repeat (5) step(0, 4'b0000, 4'd3);
      // full rotation, slice 3
      repeat (16) step(0, 4'b1111, 4'd3);
      // lone requester re-granted every 2 cycles
      step(1, 4'b0000, 4'd2);
      repeat (8) step(0, 4'b0100, 4'd2);
      // owner 1 drops at cnt 3 with req 3 pending
      step(1, 4'b0000, 4'd8);
      step(0, 4'b0001, 4'd8);
      step(0, 4'b0000, 4'd8);
      step(0, 4'b0010, 4'd8);
      repeat (3) step(0, 4'b1010, 4'd8);
      repeat (4) step(0, 4'b1000, 4'd8);
      // slice_len 0 means 16 cycles
      step(1, 4'b0000, 4'd0);
      repeat (36) step(0, 4'b0001, 4'd0);
      // reset mid-slice, then req 1 wins first
      step(1, 4'b0000, 4'd8);
      repeat (6) step(0, 4'b1010, 4'd8);
      step(1, 4'b1010, 4'd8);
      repeat (4) step(0, 4'b1010, 4'd8);
      // drop coincides with expiry
      step(1, 4'b0000, 4'd2);
      step(0, 4'b0011, 4'd2);
      step(0, 4'b0011, 4'd2);
      step(0, 4'b0010, 4'd2);
      step(0, 4'b0010, 4'd2);
      step(0, 4'b0000, 4'd2);
      repeat (2) step(0, 4'b0000, 4'd2);
      // randomized traffic
      begin
         logic [3:0] rq, sl;
         rq = 4'b0000;
         sl = 4'd3;
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) sl = 4'($urandom_range(0, 5));
            step(($urandom_range(0, 99) == 0), rq, sl);
         end
      end
      repeat (3) @(posedge clk);
      #2;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain left=%0d want=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/slice_rr_arbiter.md
Name: slice_rr_arbiter

Overview:
- Round-robin arbiter that shares one time-sliced resource among NREQ requesters.
- Owns an internal up-counter (enable/reset/overflow style) that measures each grant's time slice.
- Rotates ownership when the slice expires or when the owner drops its request.
- Sits in front of shared counter/datapath blocks and sequences which client drives them.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..16.
- ID_W, 2, width of grant_id; must equal log2(NREQ).
- SLICE_W, 4, width of slice length and slice counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  request per client; level, held while service wanted
- slice_len  input  SLICE_W  slice length in cycles, sampled at each grant; 0 means 2^SLICE_W
- grant  output  NREQ  one-hot grant, registered; all-zero when idle
- grant_valid  output  1  high while any grant is asserted
- grant_id  output  ID_W  binary index of current owner; 0 when idle
- slice_cnt  output  SLICE_W  cycles elapsed in current slice, 0-based
- expire  output  1  one-cycle pulse: owner's slice ran out while its req was still high

Behaviour:
- Reset (reset sampled high at a clk edge): grant=0, grant_valid=0, grant_id=0, slice_cnt=0, expire=0, state=IDLE, last pointer=NREQ-1 (req[0] has first priority). Overrides everything, including mid-slice; grant drops at that edge.
- States: IDLE, BUSY.
- Arbitration function: winner = first index i with req[i]=1, searching (last+1), (last+2), ... mod NREQ, wrapping through last itself.
- IDLE:
  - If any req is high at an edge, go to BUSY: grant[winner]=1, grant_id=winner, last=winner, slice_cnt=0, latch slice_len.
  - One-cycle latency from req to grant. No req: stay IDLE.
- BUSY, each edge, priority order:
  1. req[owner]=0 (drop): release. If another req is high, grant the arbitration winner at this same edge (no idle gap) with slice_cnt=0 and a fresh slice_len sample. Otherwise go to IDLE and clear grant. No expire pulse.
  2. slice_cnt == latched_len-1 with req[owner]=1 (expiry): expire=1 for the next cycle.
     - If other reqs are pending, grant the winner, which excludes the owner because the search starts at last+1.
     - If only the owner is requesting, re-grant the owner: slice_cnt=0, new slice_len sample.
  3. Otherwise: slice_cnt increments by 1; grant held.
- Drop and expiry in the same cycle: treated as a drop (rule 1); no expire.
- latched_len=0 means 2^SLICE_W. Expiry then occurs at slice_cnt = all-ones; the counter never wraps silently.
- slice_len changes mid-slice have no effect until the next grant.
- Grant is always one-hot or zero. grant_valid == |grant. grant_id is consistent with grant in the same cycle.
- Non-owner req changes mid-slice do not disturb the current grant.
- Fairness: with all requesters continuously requesting, each is granted exactly once per NREQ slices.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, slice_cnt=0, expire=0 throughout.
- slice_len=3, req=4'b1111 held -> grants 0,1,2,3,0 in order; each lasts 3 cycles (slice_cnt 0,1,2); expire pulses once per handoff; no idle gap.
- slice_len=2, req=4'b0100 held alone -> grant_id=2 continuously; slice_cnt cycles 0,1,0,1; expire pulses every 2 cycles; grant never drops.
- Owner 1 granted with slice_len=8, req[1] dropped at slice_cnt=3 while req[3]=1 -> grant moves to 3 at that edge; slice_cnt=0; no expire.
- slice_len=0, single requester -> slice_cnt counts 0..15; expire at the 16th cycle; counter restarts at 0.
- reset asserted at slice_cnt=5 with req=4'b1010 -> all outputs cleared at that edge; after release, req[1] is granted first (pointer reset to NREQ-1).
- Drop and expiry in the same cycle (slice_len=2, drop req[owner] at slice_cnt=1) -> handoff or IDLE per remaining reqs; expire stays 0.
